// File: rtl/i2c_reg_arbiter_pkg.sv
// rtl/i2c_reg_arbiter_pkg.sv - shared types, constants and helpers for the I2C register arbiter
package i2c_regs_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LOCK,
    ACK
  } arb_state_t;

  localparam int TXN_CNT_MAX = 255;

  function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/i2c_reg_arbiter_if.sv
// rtl/i2c_reg_arbiter_if.sv - I2C slave register port, local fabric port and update/summary outputs
interface i2c_reg_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic                  i2c_write_en;
  logic [ADDR_WIDTH-1:0] i2c_reg_addr;
  logic [DATA_WIDTH-1:0] i2c_wdata;
  logic [DATA_WIDTH-1:0] i2c_rdata;
  logic                  i2c_busy;
  logic                  i2c_done;
  logic                  lock_en;
  logic                  loc_req;
  logic                  loc_we;
  logic [ADDR_WIDTH-1:0] loc_addr;
  logic [DATA_WIDTH-1:0] loc_wdata;
  logic                  loc_ack;
  logic [DATA_WIDTH-1:0] loc_rdata;
  logic                  loc_err;
  logic                  upd_valid;
  logic [ADDR_WIDTH-1:0] upd_addr;
  logic                  txn_done;
  logic [7:0]            txn_wr_count;

  modport master (
    output i2c_write_en, i2c_reg_addr, i2c_wdata, i2c_busy, i2c_done, lock_en,
    output loc_req, loc_we, loc_addr, loc_wdata,
    input  i2c_rdata, loc_ack, loc_rdata, loc_err, upd_valid, upd_addr, txn_done, txn_wr_count
  );

  modport slave (
    input  i2c_write_en, i2c_reg_addr, i2c_wdata, i2c_busy, i2c_done, lock_en,
    input  loc_req, loc_we, loc_addr, loc_wdata,
    output i2c_rdata, loc_ack, loc_rdata, loc_err, upd_valid, upd_addr, txn_done, txn_wr_count
  );
endinterface

// File: rtl/i2c_reg_arbiter_bank.sv
// rtl/i2c_reg_arbiter_bank.sv - register storage with an I2C/local muxed write port and two read ports
module i2c_reg_bank
  import i2c_regs_pkg::*;
#(
  parameter int              ADDR_WIDTH = 8,
  parameter int              DATA_WIDTH = 16,
  parameter int              DEPTH      = 16,
  parameter logic [DEPTH-1:0] RO_MASK   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i2c_we,
  input  logic [ADDR_WIDTH-1:0] i2c_addr,
  input  logic [DATA_WIDTH-1:0] i2c_wdata,
  input  logic                  loc_we,
  input  logic [ADDR_WIDTH-1:0] loc_addr,
  input  logic [DATA_WIDTH-1:0] loc_wdata,
  output logic                  i2c_accept,
  output logic [DATA_WIDTH-1:0] i2c_rd,
  output logic [DATA_WIDTH-1:0] loc_rd
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [IDX_W-1:0]      i2c_idx;
  logic [IDX_W-1:0]      loc_idx;
  logic                  i2c_ok;
  logic                  loc_ok;

  assign i2c_idx    = i2c_addr[IDX_W-1:0];
  assign loc_idx    = loc_addr[IDX_W-1:0];
  assign i2c_ok     = addr_in_range(32'(i2c_addr), DEPTH);
  assign loc_ok     = addr_in_range(32'(loc_addr), DEPTH);
  // Read-only protection applies to the I2C side only; local writes may still update.
  assign i2c_accept = i2c_we & i2c_ok & ~RO_MASK[i2c_idx];

  assign i2c_rd = i2c_ok ? regs[i2c_idx] : '0;
  assign loc_rd = loc_ok ? regs[loc_idx] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (i2c_we) begin
      if (i2c_accept) regs[i2c_idx] <= i2c_wdata;
    end else if (loc_we) begin
      regs[loc_idx] <= loc_wdata;
    end
  end
endmodule

// File: rtl/i2c_reg_arbiter.sv
// rtl/i2c_reg_arbiter.sv - register bank arbiter between the I2C slave strobe and a stallable local port
module i2c_reg_arbiter
  import i2c_regs_pkg::*;
#(
  parameter int              ADDR_WIDTH = 8,
  parameter int              DATA_WIDTH = 16,
  parameter int              DEPTH      = 16,
  parameter logic [DEPTH-1:0] RO_MASK   = '0
) (
  input logic          clk,
  input logic          reset,
  i2c_reg_arbiter_if.slave bus
);
  arb_state_t            state;
  logic [7:0]            wr_cnt;
  logic [7:0]            cnt_next;
  logic                  i2c_accept;
  logic [DATA_WIDTH-1:0] i2c_rd;
  logic [DATA_WIDTH-1:0] loc_rd;
  logic                  loc_in_range;
  logic                  lock_hold;
  logic                  commit;
  logic                  commit_wr;

  assign loc_in_range = addr_in_range(32'(bus.loc_addr), DEPTH);
  assign lock_hold    = bus.loc_we & bus.lock_en & bus.i2c_busy;
  assign commit       = (state == IDLE) & bus.loc_req & ~bus.i2c_write_en & ~lock_hold;
  assign commit_wr    = commit & bus.loc_we & loc_in_range;
  assign cnt_next     = (i2c_accept && wr_cnt != 8'(TXN_CNT_MAX)) ? wr_cnt + 8'd1 : wr_cnt;

  i2c_reg_bank #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .RO_MASK   (RO_MASK)
  ) u_bank (
    .clk       (clk),
    .reset     (reset),
    .i2c_we    (bus.i2c_write_en),
    .i2c_addr  (bus.i2c_reg_addr),
    .i2c_wdata (bus.i2c_wdata),
    .loc_we    (commit_wr),
    .loc_addr  (bus.loc_addr),
    .loc_wdata (bus.loc_wdata),
    .i2c_accept(i2c_accept),
    .i2c_rd    (i2c_rd),
    .loc_rd    (loc_rd)
  );

  // The I2C strobe cannot stall, so a local request simply retries while it is present.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bus.loc_ack   <= 1'b0;
      bus.loc_err   <= 1'b0;
      bus.loc_rdata <= '0;
    end else begin
      bus.loc_ack <= 1'b0;
      bus.loc_err <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.loc_req && !bus.i2c_write_en) begin
            if (lock_hold) begin
              state <= WAIT_LOCK;
            end else begin
              state       <= ACK;
              bus.loc_ack <= 1'b1;
              bus.loc_err <= ~loc_in_range;
              if (!loc_in_range)   bus.loc_rdata <= '0;
              else if (!bus.loc_we) bus.loc_rdata <= loc_rd;
            end
          end
        end
        WAIT_LOCK: if (!bus.i2c_busy || !bus.lock_en) state <= IDLE;
        ACK:       state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt           <= '0;
      bus.txn_done     <= 1'b0;
      bus.txn_wr_count <= '0;
      bus.upd_valid    <= 1'b0;
      bus.upd_addr     <= '0;
      bus.i2c_rdata    <= '0;
    end else begin
      bus.upd_valid <= i2c_accept;
      if (i2c_accept) bus.upd_addr <= bus.i2c_reg_addr;
      bus.i2c_rdata <= i2c_rd;
      bus.txn_done  <= bus.i2c_done;
      if (bus.i2c_done) begin
        bus.txn_wr_count <= cnt_next;
        wr_cnt           <= '0;
      end else begin
        wr_cnt <= cnt_next;
      end
    end
  end
endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// tb/tb_i2c_reg_arbiter.sv - self-checking bench for the I2C register arbiter
module tb_i2c_reg_arbiter;
  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    bit          err;
    logic [15:0] rdata;
    bit          chk_rd;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    bit          we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    bit          exp_err;
    logic [15:0] exp_rdata;
  } lvec_t;
  lvec_t tbl[11];

  i2c_reg_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();

  i2c_reg_arbiter #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(16),
    .DEPTH     (16),
    .RO_MASK   (16'h0002)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Every local ack is matched against the oldest expectation pushed at request time.
  always @(negedge clk) begin
    if (bus.loc_ack === 1'b1) begin
      if (sbq.size() == 0) begin
        check("sb_unexpected_ack", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sbq.pop_front();
        check("sb_loc_err", 32'(bus.loc_err), 32'(e.err));
        if (e.chk_rd) check("sb_loc_rdata", 32'(bus.loc_rdata), 32'(e.rdata));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_local(input bit we, input logic [7:0] a, input logic [15:0] d,
                             input bit exp_err, input logic [15:0] exp_rd);
    sb_t e;
    bus.loc_req   = 1'b1;
    bus.loc_we    = we;
    bus.loc_addr  = a;
    bus.loc_wdata = d;
    e.err    = exp_err;
    e.rdata  = exp_rd;
    e.chk_rd = !we || exp_err;
    sbq.push_back(e);
  endtask

  // Latency counts falling edges from the request drive point to the first one showing loc_ack.
  task automatic wait_ack(output int lat);
    bit got = 0;
    lat = 99;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if (bus.loc_ack === 1'b1) begin
        got = 1;
        lat = i;
      end
    end
    step();
    bus.loc_req = 1'b0;
  endtask

  task automatic i2c_write(input logic [7:0] a, input logic [15:0] d, input bit done);
    bus.i2c_reg_addr = a;
    bus.i2c_wdata    = d;
    bus.i2c_write_en = 1'b1;
    bus.i2c_done     = done;
    step();
    bus.i2c_write_en = 1'b0;
    bus.i2c_done     = 1'b0;
  endtask

  task automatic outputs_zero(input string tag);
    check({tag, "_loc_ack"},      32'(bus.loc_ack),      0);
    check({tag, "_loc_err"},      32'(bus.loc_err),      0);
    check({tag, "_loc_rdata"},    32'(bus.loc_rdata),    0);
    check({tag, "_i2c_rdata"},    32'(bus.i2c_rdata),    0);
    check({tag, "_upd_valid"},    32'(bus.upd_valid),    0);
    check({tag, "_upd_addr"},     32'(bus.upd_addr),     0);
    check({tag, "_txn_done"},     32'(bus.txn_done),     0);
    check({tag, "_txn_wr_count"}, 32'(bus.txn_wr_count), 0);
  endtask

  initial begin
    int lat;
    bit saw;

    tbl[0]  = '{1'b1, 8'h03, 16'hBEEF, 1'b0, 16'h0000};
    tbl[1]  = '{1'b0, 8'h03, 16'h0000, 1'b0, 16'hBEEF};
    tbl[2]  = '{1'b1, 8'h0F, 16'h5A5A, 1'b0, 16'h0000};
    tbl[3]  = '{1'b0, 8'h0F, 16'h0000, 1'b0, 16'h5A5A};
    tbl[4]  = '{1'b1, 8'h00, 16'h0001, 1'b0, 16'h0000};
    tbl[5]  = '{1'b0, 8'h00, 16'h0000, 1'b0, 16'h0001};
    tbl[6]  = '{1'b0, 8'h20, 16'h0000, 1'b1, 16'h0000};
    tbl[7]  = '{1'b1, 8'h10, 16'h1111, 1'b1, 16'h0000};
    tbl[8]  = '{1'b0, 8'h03, 16'h0000, 1'b0, 16'hBEEF};
    tbl[9]  = '{1'b1, 8'h01, 16'h7777, 1'b0, 16'h0000};
    tbl[10] = '{1'b0, 8'h01, 16'h0000, 1'b0, 16'h7777};

    reset = 1'b1;
    bus.i2c_write_en = 0; bus.i2c_reg_addr = 0; bus.i2c_wdata = 0;
    bus.i2c_busy = 0; bus.i2c_done = 0; bus.lock_en = 0;
    bus.loc_req = 0; bus.loc_we = 0; bus.loc_addr = 0; bus.loc_wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    outputs_zero("reset");
    step();
    reset = 1'b0;

    // Table of uncontended local accesses.
    for (int i = 0; i < 11; i++) begin
      start_local(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_err, tbl[i].exp_rdata);
      wait_ack(lat);
      check("tbl_ack_lat", 32'(lat), 2);
      if (tbl[i].we) begin
        bus.i2c_reg_addr = tbl[i].addr;
        @(posedge clk);
        @(negedge clk);
        check("tbl_i2c_rdata", 32'(bus.i2c_rdata), tbl[i].exp_err ? 32'h0 : 32'(tbl[i].wdata));
        step();
      end
    end

    // Local read and I2C write to the same address in the same cycle.
    start_local(1'b0, 8'h05, 16'h0000, 1'b0, 16'h1234);
    i2c_write(8'h05, 16'h1234, 1'b0);
    @(negedge clk);
    check("conflict_upd_valid", 32'(bus.upd_valid), 1);
    check("conflict_upd_addr",  32'(bus.upd_addr),  5);
    wait_ack(lat);
    check("conflict_ack_lat", 32'(lat + 2), 3);

    // Lock holds off a local write until the transaction ends.
    bus.lock_en  = 1'b1;
    bus.i2c_busy = 1'b1;
    start_local(1'b1, 8'h02, 16'hAAAA, 1'b0, 16'h0000);
    saw = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.loc_ack === 1'b1) saw = 1;
    end
    check("lock_hold_no_ack", 32'(saw), 0);
    step();
    bus.i2c_busy = 1'b0;
    wait_ack(lat);
    check("lock_release_lat", 32'(lat), 3);
    bus.lock_en = 1'b0;
    bus.i2c_reg_addr = 8'h02;
    @(posedge clk);
    @(negedge clk);
    check("lock_bank_value", 32'(bus.i2c_rdata), 32'hAAAA);
    step();

    // Dropped I2C writes: read-only register and out-of-range address.
    i2c_write(8'h01, 16'hDEAD, 1'b0);
    @(negedge clk);
    check("ro_no_upd", 32'(bus.upd_valid), 0);
    step();
    i2c_write(8'h20, 16'hDEAD, 1'b0);
    @(negedge clk);
    check("oor_no_upd", 32'(bus.upd_valid), 0);
    step();
    i2c_write(8'h07, 16'h0707, 1'b0);
    @(negedge clk);
    check("i2c_wr_rdata_old", 32'(bus.i2c_rdata), 0);
    check("i2c_wr_upd_valid", 32'(bus.upd_valid), 1);
    check("i2c_wr_upd_addr",  32'(bus.upd_addr),  7);
    step();
    @(negedge clk);
    check("i2c_wr_rdata_new", 32'(bus.i2c_rdata), 32'h0707);
    check("i2c_wr_upd_clear", 32'(bus.upd_valid), 0);
    step();
    bus.i2c_reg_addr = 8'h01;
    @(posedge clk);
    @(negedge clk);
    check("ro_bank_kept", 32'(bus.i2c_rdata), 32'h7777);
    step();
    bus.i2c_reg_addr = 8'h20;
    @(posedge clk);
    @(negedge clk);
    check("oor_i2c_rdata", 32'(bus.i2c_rdata), 0);
    step();
    start_local(1'b0, 8'h20, 16'h0000, 1'b1, 16'h0000);
    wait_ack(lat);
    check("oor_loc_lat", 32'(lat), 2);

    // Flush the two writes accepted so far (0x5 and 0x7).
    bus.i2c_done = 1'b1;
    step();
    bus.i2c_done = 1'b0;
    @(negedge clk);
    check("flush_txn_done",  32'(bus.txn_done),     1);
    check("flush_txn_count", 32'(bus.txn_wr_count), 2);
    step();

    // Transaction with three accepted writes, the last coinciding with i2c_done.
    bus.i2c_busy = 1'b1;
    i2c_write(8'h08, 16'h0008, 1'b0);
    step();
    i2c_write(8'h01, 16'h0BAD, 1'b0);
    i2c_write(8'h09, 16'h0009, 1'b0);
    i2c_write(8'h0A, 16'h000A, 1'b1);
    @(negedge clk);
    check("txn_done_pulse", 32'(bus.txn_done),     1);
    check("txn_count_3",    32'(bus.txn_wr_count), 3);
    step();
    @(negedge clk);
    check("txn_done_clear", 32'(bus.txn_done),     0);
    step();
    i2c_write(8'h0B, 16'h000B, 1'b0);
    bus.i2c_done = 1'b1;
    step();
    bus.i2c_done = 1'b0;
    bus.i2c_busy = 1'b0;
    @(negedge clk);
    check("txn2_done",    32'(bus.txn_done),     1);
    check("txn2_count_1", 32'(bus.txn_wr_count), 1);
    step();

    // Reset while a request is pending: no ack, everything cleared.
    start_local(1'b0, 8'h03, 16'h0000, 1'b0, 16'hBEEF);
    wait_ack(lat);
    check("pre_rst_lat", 32'(lat), 2);
    bus.i2c_reg_addr = 8'h03;
    bus.loc_req  = 1'b1;
    bus.loc_we   = 1'b0;
    bus.loc_addr = 8'h03;
    #2;
    reset = 1'b1;
    saw = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.loc_ack === 1'b1) saw = 1;
    end
    check("rst_no_ack", 32'(saw), 0);
    outputs_zero("midrst");
    step();
    bus.loc_req = 1'b0;
    reset = 1'b0;
    start_local(1'b0, 8'h03, 16'h0000, 1'b0, 16'h0000);
    wait_ack(lat);
    check("post_rst_lat", 32'(lat), 2);
    @(negedge clk);
    check("post_rst_i2c_rdata", 32'(bus.i2c_rdata), 0);
    step();

    check("sb_drained", 32'(sbq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
